// File: rtl/three_btn_debounce.sv
// Three-channel switch debouncer. Each raw line passes through a two-flop
// synchronizer and then its own four-state FSM, which commits a new level
// only after it has been seen steadily for STABLE_CYCLES clock edges.
// Registered rise/fall pulses mark each committed change for one cycle.
module three_btn_debounce #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn_in,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic [2:0] rise,
  output logic [2:0] fall
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  localparam logic [1:0] ST_STABLE_LO = 2'd0;
  localparam logic [1:0] ST_WAIT_HI   = 2'd1;
  localparam logic [1:0] ST_STABLE_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO   = 2'd3;

  logic [2:0] s1;
  logic [2:0] s2;
  logic [2:0] out_vec;
  logic [2:0] rise_vec;
  logic [2:0] fall_vec;

  // Two-flop synchronizer: the only reader of the raw asynchronous lines.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, giving a true two-stage pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_chan
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          out_q;
    logic          out_d;
    logic          rise_q;
    logic          fall_q;

    // Next-state logic: count consecutive mismatching edges, restart on any
    // single-cycle return to the committed level.
    always_comb begin
      // NOTE: defaults first so every path assigns every signal; without
      // them a missed branch would infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_STABLE_LO: begin
          cnt_d = '0;
          if (s2[ch]) begin
            if (STABLE_CYCLES == 1) begin
              state_d = ST_STABLE_HI;
            end else begin
              state_d = ST_WAIT_HI;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ST_WAIT_HI: begin
          if (!s2[ch]) begin
            state_d = ST_STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_STABLE_HI;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_STABLE_HI: begin
          cnt_d = '0;
          if (!s2[ch]) begin
            if (STABLE_CYCLES == 1) begin
              state_d = ST_STABLE_LO;
            end else begin
              state_d = ST_WAIT_LO;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ST_WAIT_LO: begin
          if (s2[ch]) begin
            state_d = ST_STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_STABLE_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end
      endcase
      out_d = (state_d == ST_STABLE_HI) || (state_d == ST_WAIT_LO);
    end

    // State, counter, registered output and edge pulses for this channel.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_STABLE_LO;
        cnt_q   <= '0;
        out_q   <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
        rise_q  <= out_d & ~out_q;
        fall_q  <= ~out_d & out_q;
      end
    end

    assign out_vec[ch]  = out_q;
    assign rise_vec[ch] = rise_q;
    assign fall_vec[ch] = fall_q;
  end

  assign A    = out_vec[0];
  assign B    = out_vec[1];
  assign C    = out_vec[2];
  assign rise = rise_vec;
  assign fall = fall_vec;

endmodule

// File: doc/three_btn_debounce.md
THREE_BTN_DEBOUNCE -- requirements
Module: three_btn_debounce

Upstream conditioning stage for the three-input OR block. It turns three raw, bouncing switch/button lines into clean, synchronous levels A, B, C that drive the OR block's inputs directly.

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: the number of consecutive clock cycles a synchronized input must differ from its output before that output toggles; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 SHALL have port btn_in, input, 3 bits: raw asynchronous lines; bit0 feeds A, bit1 feeds B, bit2 feeds C.
REQ-005 SHALL have port A, output, 1 bit: debounced level of btn_in[0].
REQ-006 SHALL have port B, output, 1 bit: debounced level of btn_in[1].
REQ-007 SHALL have port C, output, 1 bit: debounced level of btn_in[2].
REQ-008 SHALL have port rise, output, 3 bits: one-cycle pulse on bit n when debounced output n goes 0->1.
REQ-009 SHALL have port fall, output, 3 bits: one-cycle pulse on bit n when debounced output n goes 1->0.

Function
REQ-010 SHALL pass each btn_in bit through a two-flop synchronizer (s1, s2) before any other use; no other logic SHALL read btn_in directly.
REQ-011 SHALL give each channel its own independent counter, CW = clog2(STABLE_CYCLES+1) bits wide; the three channels SHALL share no state.
REQ-012 Each channel SHALL implement a four-state FSM:
- STABLE_LO: output 0, counter 0. If s2=1, go to WAIT_HI with counter=1.
- WAIT_HI: if s2=0, return to STABLE_LO and clear the counter. If s2=1 and counter=STABLE_CYCLES-1, go to STABLE_HI. Otherwise increment the counter.
- STABLE_HI and WAIT_LO: mirror images of the above with polarity inverted.
REQ-013 SHALL drive the debounced output directly from a register: 1 in STABLE_HI and WAIT_LO, 0 in STABLE_LO and WAIT_HI.
REQ-014 SHALL update the output on the clock edge of the STABLE_CYCLES-th consecutive edge on which s2 differs from the output. The output change SHALL become visible STABLE_CYCLES+2 edges after the first edge that samples the new raw value into s1.
REQ-015 SHALL, on any single-cycle return of s2 to the current output level while in a WAIT state, return to the matching STABLE state and clear the counter with no output change; counting restarts from zero.
REQ-016 SHALL, when STABLE_CYCLES=1, toggle the output on the first edge of mismatch; the WAIT states are then transient and never hold for more than one cycle.
REQ-017 SHALL register rise[n]/fall[n] so that they are high in exactly the cycle after the edge on which output n changed, for one cycle only.
REQ-018 SHALL never assert rise[n] and fall[n] in the same cycle.
REQ-019 SHALL allow channels to toggle simultaneously; rise and fall may carry several set bits in the same cycle.
REQ-020 SHALL never let the counter exceed STABLE_CYCLES-1 and SHALL never wrap.

Reset
REQ-021 SHALL, on a clock edge with rst_n=0, set s1=s2=0, all FSMs to STABLE_LO, all counters to 0, A=B=C=0, rise=0 and fall=0, regardless of btn_in.
REQ-022 SHALL, when reset is asserted mid-WAIT, abandon the in-progress count; after rst_n returns to 1 a held-high input SHALL need the full STABLE_CYCLES+2 edges again.
REQ-023 SHALL, while rst_n=0, hold all outputs at their reset values on every edge.

Verification
REQ-024 Clean press: STABLE_CYCLES=4, btn_in 000->001 held, first sampled at edge k -> A=1 after edge k+5, rise=001 for exactly one cycle, B and C stay 0.
REQ-025 Bounce rejection: btn_in[1] toggles 1,0,1,0,1 with one cycle each, then holds 1 -> B stays 0 throughout the bounce, rises only STABLE_CYCLES+2 edges after the final 0->1, and produces exactly one rise pulse.
REQ-026 Release: A=1 steady, btn_in[0] drops to 0 and holds -> A=0 after STABLE_CYCLES+2 edges, fall=001 for one cycle, rise stays 000.
REQ-027 Simultaneous: btn_in 000->111 in one cycle -> A, B and C all go to 1 on the same edge, rise=111 for one cycle.
REQ-028 Reset mid-count: btn_in[2]=1 held, rst_n=0 for one edge during WAIT_HI, then released -> C=0 at the reset edge and C=1 only STABLE_CYCLES+2 edges after release.
REQ-029 Minimum parameter: STABLE_CYCLES=1, btn_in 000->010 -> B=1 after 3 edges, rise=010 for one cycle.
